// File: rtl/ball_datapath.sv
// Pong ball datapath: steps the ball once per frame, detects paddle, border and miss events,
// and keeps the score and serve/game-over sequencing. All outputs are registered.
module ball_datapath #(
  parameter int H_ACTIVE       = 640,
  parameter int V_ACTIVE       = 480,
  parameter int BALL_SIZE      = 8,
  parameter int PADDLE_W       = 8,
  parameter int PADDLE_H       = 64,
  parameter int LEFT_PADDLE_X  = 16,
  parameter int RIGHT_PADDLE_X = 616,
  parameter int SERVE_FRAMES   = 60,
  parameter int WIN_SCORE      = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [3:0] cw_ballMovement,
  input  logic [9:0] paddle_left_y,
  input  logic [9:0] paddle_right_y,
  output logic [3:0] sw_ballMovement,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic       game_over
);

  localparam logic [9:0]  CX         = 10'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0]  CY         = 10'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0]  X_MAX      = 10'(H_ACTIVE - BALL_SIZE);
  localparam logic [9:0]  Y_MAX      = 10'(V_ACTIVE - BALL_SIZE);
  localparam logic [9:0]  L_FACE     = 10'(LEFT_PADDLE_X + PADDLE_W);
  localparam logic [10:0] BS11       = 11'(BALL_SIZE);
  localparam logic [10:0] PH11       = 11'(PADDLE_H);
  localparam logic [10:0] R_FACE11   = 11'(RIGHT_PADDLE_X);
  localparam logic [3:0]  WIN4       = 4'(WIN_SCORE);
  localparam logic [7:0]  SERVE_LAST = 8'(SERVE_FRAMES - 1);

  typedef enum logic [2:0] {S_SERVE, S_IDLE, S_MOVE, S_CHECK, S_OVER} state_t;

  state_t     state_q;
  logic [7:0] cnt_q;
  logic [9:0] x_q, y_q;
  logic [3:0] sw_q, sl_q, sr_q;
  logic       go_q;

  logic       xp, xn, yp, yn;
  logic [9:0] x_d, y_d;
  logic [3:0] sl_inc, sr_inc;
  logic [10:0] x11, y11, pr11, pl11;
  logic       miss_l, miss_r, hit_r, hit_l, hit_top, hit_bot;

  // Undefined codes decode to no direction, which also means no event can match.
  assign xp = (cw_ballMovement == 4'b0001) || (cw_ballMovement == 4'b0100);
  assign xn = (cw_ballMovement == 4'b0010) || (cw_ballMovement == 4'b0011);
  assign yp = (cw_ballMovement == 4'b0001) || (cw_ballMovement == 4'b0011);
  assign yn = (cw_ballMovement == 4'b0100) || (cw_ballMovement == 4'b0010);

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (xp && x_q < X_MAX) x_d = x_q + 10'd1;
    if (xn && x_q != 10'd0) x_d = x_q - 10'd1;
    if (yp && y_q < Y_MAX) y_d = y_q + 10'd1;
    if (yn && y_q != 10'd0) y_d = y_q - 10'd1;
  end

  assign x11  = {1'b0, x_q};
  assign y11  = {1'b0, y_q};
  assign pr11 = {1'b0, paddle_right_y};
  assign pl11 = {1'b0, paddle_left_y};

  assign miss_l  = xn && (x_q == 10'd0);
  assign miss_r  = xp && (x_q == X_MAX);
  assign hit_r   = xp && (x11 + BS11 == R_FACE11) && (y11 + BS11 > pr11) && (y11 < pr11 + PH11);
  assign hit_l   = xn && (x_q == L_FACE) && (y11 + BS11 > pl11) && (y11 < pl11 + PH11);
  assign hit_top = yn && (y_q == 10'd0);
  assign hit_bot = yp && (y_q == Y_MAX);

  assign sl_inc = sl_q + 4'd1;
  assign sr_inc = sr_q + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_SERVE;
      cnt_q   <= '0;
      x_q     <= CX;
      y_q     <= CY;
      sw_q    <= '0;
      sl_q    <= '0;
      sr_q    <= '0;
      go_q    <= 1'b0;
    end else begin
      sw_q <= '0;
      case (state_q)
        S_SERVE: begin
          x_q <= CX;
          y_q <= CY;
          if (frame_tick) begin
            if (cnt_q == SERVE_LAST) begin
              cnt_q   <= '0;
              state_q <= S_IDLE;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        S_IDLE: if (frame_tick) state_q <= S_MOVE;
        S_MOVE: begin
          x_q     <= x_d;
          y_q     <= y_d;
          state_q <= S_CHECK;
        end
        S_CHECK: begin
          state_q <= S_IDLE;
          if (miss_l || miss_r) begin
            sw_q <= 4'b0101;
            x_q  <= CX;
            y_q  <= CY;
            if (miss_l) sr_q <= sr_inc;
            else        sl_q <= sl_inc;
            if ((miss_l && sr_inc == WIN4) || (!miss_l && sl_inc == WIN4)) begin
              go_q    <= 1'b1;
              state_q <= S_OVER;
            end else begin
              state_q <= S_SERVE;
            end
          end else if (hit_r) begin
            sw_q <= 4'b0001;
          end else if (hit_l) begin
            sw_q <= 4'b0010;
          end else if (hit_top) begin
            sw_q <= 4'b0011;
          end else if (hit_bot) begin
            sw_q <= 4'b0100;
          end
        end
        S_OVER: state_q <= S_OVER;
        default: state_q <= S_SERVE;
      endcase
    end
  end

  assign sw_ballMovement = sw_q;
  assign ball_x          = x_q;
  assign ball_y          = y_q;
  assign score_left      = sl_q;
  assign score_right     = sr_q;
  assign game_over       = go_q;

endmodule

// File: tb/tb_ball_datapath.sv
// Directed bench for ball_datapath: serve, bounces, paddle hits, misses, corner priority,
// game over, ignored ticks and mid-CHECK reset, all against hand-computed values.
module tb_ball_datapath;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic [3:0] cw_ballMovement;
  logic [9:0] paddle_left_y;
  logic [9:0] paddle_right_y;
  logic [3:0] sw_ballMovement;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [3:0] score_left;
  logic [3:0] score_right;
  logic       game_over;

  int n_checks = 0;
  int n_fail   = 0;

  ball_datapath dut (
    .clk             (clk),
    .reset           (reset),
    .frame_tick      (frame_tick),
    .cw_ballMovement (cw_ballMovement),
    .paddle_left_y   (paddle_left_y),
    .paddle_right_y  (paddle_right_y),
    .sw_ballMovement (sw_ballMovement),
    .ball_x          (ball_x),
    .ball_y          (ball_y),
    .score_left      (score_left),
    .score_right     (score_right),
    .game_over       (game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_x"},  int'(ball_x), 316);
    check({tag, "_y"},  int'(ball_y), 236);
    check({tag, "_sw"}, int'(sw_ballMovement), 0);
    check({tag, "_sl"}, int'(score_left), 0);
    check({tag, "_sr"}, int'(score_right), 0);
    check({tag, "_go"}, int'(game_over), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // One frame: tick sampled on the first edge, then three more edges to see the sw pulse.
  // With glitch set the tick stays high through the MOVE and CHECK edges.
  task automatic frame(input bit glitch, output int pulses, output logic [3:0] sw_last);
    pulses  = 0;
    sw_last = 4'd0;
    frame_tick = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (i == 0 && !glitch) frame_tick = 1'b0;
      if (i == 2) frame_tick = 1'b0;
      if (sw_ballMovement != 4'd0) begin
        pulses++;
        sw_last = sw_ballMovement;
      end
    end
  endtask

  task automatic run(input int n, input logic [3:0] cw, output int events, output logic [3:0] last_sw);
    int p;
    logic [3:0] s;
    events  = 0;
    last_sw = 4'd0;
    cw_ballMovement = cw;
    for (int f = 0; f < n; f++) begin
      frame(1'b0, p, s);
      events += p;
      if (p != 0) last_sw = s;
    end
  endtask

  initial begin
    int         ev, p;
    logic [3:0] sw;

    reset = 1'b1;
    frame_tick = 1'b0;
    cw_ballMovement = 4'b0010;
    paddle_left_y = 10'd40;
    paddle_right_y = 10'd0;
    do_reset();
    check_reset_state("reset");

    // Serve hold, then the first movement frame.
    run(60, 4'b0010, ev, sw);
    check("serve_events", ev, 0);
    check("serve_x", int'(ball_x), 316);
    check("serve_y", int'(ball_y), 236);
    frame(1'b0, p, sw);
    check("f1_x", int'(ball_x), 315);
    check("f1_y", int'(ball_y), 235);
    check("f1_pulses", p, 0);

    // Tick held high through MOVE/CHECK still steps only once.
    frame(1'b1, p, sw);
    check("glitch_x", int'(ball_x), 314);
    check("glitch_y", int'(ball_y), 234);

    // Top bounce at movement frame 236.
    run(233, 4'b0010, ev, sw);
    check("pre_top_events", ev, 0);
    frame(1'b0, p, sw);
    check("top_x", int'(ball_x), 80);
    check("top_y", int'(ball_y), 0);
    check("top_pulses", p, 1);
    check("top_sw", int'(sw), 3);
    cw_ballMovement = 4'b0011;
    frame(1'b0, p, sw);
    check("after_top_x", int'(ball_x), 79);
    check("after_top_y", int'(ball_y), 1);

    // Left paddle hit at movement frame 292.
    run(54, 4'b0011, ev, sw);
    check("pre_lpad_events", ev, 0);
    frame(1'b0, p, sw);
    check("lpad_x", int'(ball_x), 24);
    check("lpad_y", int'(ball_y), 56);
    check("lpad_pulses", p, 1);
    check("lpad_sw", int'(sw), 2);

    // Same path with the paddle out of the way: the ball is missed on the left.
    paddle_left_y = 10'd200;
    do_reset();
    run(60, 4'b0010, ev, sw);
    run(236, 4'b0010, ev, sw);
    check("miss_top_events", ev, 1);
    run(56, 4'b0011, ev, sw);
    check("miss_x24_events", ev, 0);
    check("miss_x24_x", int'(ball_x), 24);
    check("miss_x24_y", int'(ball_y), 56);
    run(23, 4'b0011, ev, sw);
    check("miss_pre_events", ev, 0);
    check("miss_pre_x", int'(ball_x), 1);
    frame(1'b0, p, sw);
    check("miss_pulses", p, 1);
    check("miss_sw", int'(sw), 5);
    check("miss_sr", int'(score_right), 1);
    check("miss_sl", int'(score_left), 0);
    check("miss_x", int'(ball_x), 316);
    check("miss_y", int'(ball_y), 236);
    frame(1'b0, p, sw);
    check("miss_serve_hold_x", int'(ball_x), 316);

    // Corner: right paddle face and bottom border reached on the same frame.
    paddle_right_y = 10'd420;
    run(59, 4'b0011, ev, sw);
    check("serve2_events", ev, 0);
    run(28, 4'b0100, ev, sw);
    check("corner_leg1_events", ev, 0);
    check("corner_leg1_y", int'(ball_y), 208);
    run(263, 4'b0001, ev, sw);
    check("corner_leg2_events", ev, 0);
    frame(1'b0, p, sw);
    check("corner_x", int'(ball_x), 608);
    check("corner_y", int'(ball_y), 472);
    check("corner_pulses", p, 1);
    check("corner_sw", int'(sw), 1);
    frame(1'b0, p, sw);
    check("corner_next_x", int'(ball_x), 609);
    check("corner_next_y", int'(ball_y), 472);
    check("corner_next_sw", int'(sw), 4);

    // Right-side misses score for the left player until the game ends.
    paddle_right_y = 10'd0;
    run(22, 4'b0001, ev, sw);
    check("slide_events", ev, 22);
    check("slide_x", int'(ball_x), 631);
    frame(1'b0, p, sw);
    check("lpt1_sw", int'(sw), 5);
    check("lpt1_sl", int'(score_left), 1);
    for (int k = 2; k <= 9; k++) begin
      run(60, 4'b0001, ev, sw);
      check("lpt_serve_events", ev, 0);
      run(316, 4'b0001, ev, sw);
      check("lpt_events", ev, 81);
      check("lpt_sw", int'(sw), 5);
      check("lpt_sl", int'(score_left), k);
      check("lpt_go", int'(game_over), (k == 9) ? 1 : 0);
    end
    check("over_sr", int'(score_right), 1);
    check("over_x", int'(ball_x), 316);
    check("over_y", int'(ball_y), 236);

    // OVER is sticky.
    run(10, 4'b0001, ev, sw);
    check("over_hold_events", ev, 0);
    check("over_hold_x", int'(ball_x), 316);
    check("over_hold_y", int'(ball_y), 236);
    check("over_hold_sl", int'(score_left), 9);
    check("over_hold_go", int'(game_over), 1);

    // Reset during CHECK squashes the pending top-border pulse.
    do_reset();
    check_reset_state("reset2");
    run(60, 4'b0100, ev, sw);
    run(235, 4'b0100, ev, sw);
    check("rst_pre_events", ev, 0);
    check("rst_pre_y", int'(ball_y), 1);
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    @(posedge clk);
    #1;
    check("rst_check_x", int'(ball_x), 552);
    check("rst_check_y", int'(ball_y), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state("midcheck");
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_sw", int'(sw_ballMovement), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ball_datapath.md
Name: ball_datapath

Overview:
- Ball-motion datapath for Pong. It holds the ball position and steps it once per video frame in the direction given by the ball-movement control word.
- Each frame it detects collisions with paddles and borders and with missed balls. It reports each event to the ball-movement FSM as a one-cycle set word.
- It also keeps both players' scores and the serve/game-over sequencing.
- Inputs come from the VGA timing block (frame tick) and the paddle datapaths. Outputs feed the ball-movement FSM and the pixel renderer.

Parameters:
- H_ACTIVE, 640: visible width in pixels.
- V_ACTIVE, 480: visible height in pixels.
- BALL_SIZE, 8: ball edge length in pixels (square ball).
- PADDLE_W, 8: paddle width in pixels.
- PADDLE_H, 64: paddle height in pixels.
- LEFT_PADDLE_X, 16: x coordinate of the left paddle's left edge.
- RIGHT_PADDLE_X, 616: x coordinate of the right paddle's left edge.
- SERVE_FRAMES, 60: frames the ball is held at centre before each serve.
- WIN_SCORE, 9: score at which the game ends.

Ports:
- clk  in  1  system clock (25.175 MHz pixel clock).
- reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per frame, at start of vertical blank.
- cw_ballMovement  in  4  direction control word: 0001 +x+y, 0100 +x-y, 0010 -x-y, 0011 -x+y, 0101 hold/reset.
- paddle_left_y  in  10  y coordinate of the left paddle's top edge.
- paddle_right_y  in  10  y coordinate of the right paddle's top edge.
- sw_ballMovement  out  4  event set word: 0001 right paddle, 0010 left paddle, 0011 top border, 0100 bottom border, 0101 point scored, 0000 none.
- ball_x  out  10  x coordinate of the ball's left edge.
- ball_y  out  10  y coordinate of the ball's top edge.
- score_left  out  4  left player's score, 0..WIN_SCORE.
- score_right  out  4  right player's score, 0..WIN_SCORE.
- game_over  out  1  high once either score reaches WIN_SCORE.

Behaviour:
- All outputs are registered. Centre position is CX=(H_ACTIVE-BALL_SIZE)/2=316, CY=(V_ACTIVE-BALL_SIZE)/2=236.
- Reset: ball_x=316, ball_y=236, sw=0000, both scores 0, game_over=0, serve counter 0, state SERVE.
- States: SERVE, IDLE, MOVE, CHECK, OVER. frame_tick is only sampled in SERVE, IDLE and OVER; a tick arriving in MOVE or CHECK is ignored.
- SERVE: each frame_tick increments the serve counter. When the counter reaches SERVE_FRAMES, clear it and go to IDLE. The ball is held at centre.
- IDLE: frame_tick -> MOVE on the next cycle.
- MOVE (one cycle): x changes by +/-1 and y by +/-1 per cw_ballMovement. cw 0101 or any undefined code -> no movement. Results clamp to 0..H_ACTIVE-BALL_SIZE in x and 0..V_ACTIVE-BALL_SIZE in y. Next state is CHECK.
- CHECK (one cycle): evaluate the updated position. sw_ballMovement is registered from this evaluation and is high for exactly one cycle, the cycle after CHECK. It is 0000 on every other cycle. Next state is IDLE, or SERVE/OVER after a point. Priority, first match wins:
  1. Miss, moving -x and ball_x==0: sw=0101, score_right+1.
  2. Miss, moving +x and ball_x==H_ACTIVE-BALL_SIZE: sw=0101, score_left+1.
  3. Right paddle: moving +x, ball_x+BALL_SIZE==RIGHT_PADDLE_X, ball_y+BALL_SIZE>paddle_right_y, and ball_y<paddle_right_y+PADDLE_H: sw=0001.
  4. Left paddle: moving -x, ball_x==LEFT_PADDLE_X+PADDLE_W, with the same overlap test against paddle_left_y: sw=0010.
  5. Top border: moving -y and ball_y==0: sw=0011.
  6. Bottom border: moving +y and ball_y==V_ACTIVE-BALL_SIZE: sw=0100.
- Simultaneous paddle and border hit (corner): the paddle event wins this frame. The y clamp holds the ball at the border, so the border event fires next frame.
- On a point: ball_x/ball_y reload CX/CY in the same cycle that sw=0101 is registered.
  - If the new score equals WIN_SCORE: set game_over and go to OVER.
  - Otherwise go to SERVE.
- Movement timing: a tick at cycle N gives MOVE at N+1, position visible at N+2, and the sw pulse at N+3. The FSM updates cw by N+4, so direction always settles before the next frame.
- OVER: the ball is frozen at centre, sw=0000, and scores and game_over hold. Only reset exits.
- Reset mid-operation: takes effect on the next clk edge from any state, including clearing an sw pulse in flight.

Test Plan:
- Reset then SERVE_FRAMES=60 ticks, cw=0010 -> no motion during serve. The first tick after serve gives (315,235); sw stays 0000.
- Top bounce: cw=0010 for 236 movement frames -> ball_y=0, sw=0011 for exactly one cycle. With cw=0011 next frame -> (79,1).
- Left paddle hit: continue with cw=0011 to movement frame 292, paddle_left_y=40 -> ball=(24,56), sw=0010 for one cycle.
- Left miss: same path with paddle_left_y=200 -> no sw at x=24. At frame 316 ball_x=0, then sw=0101, score_right=1, ball=(316,236), state SERVE.
- Corner priority: right paddle overlap coincident with ball_y=V_ACTIVE-BALL_SIZE -> sw=0001 this frame and sw=0100 on the following frame.
- Game over and glitches: drive score_left to 9 -> game_over=1 and the ball frozen through 10 further ticks. A frame_tick during MOVE/CHECK is ignored. Asserting reset mid-CHECK -> sw=0000 and all registers at reset values on the next edge.
